// File: rtl/axil_cmd_master.sv
// ============================================================================
// Module   : axil_cmd_master
// Purpose  : Single-transaction AXI4-Lite master driven by a pulse command port.
//            Runs one write (AW+W -> B) or one read (AR -> R) per command and
//            reports response code, read data and elapsed cycle count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axil_cmd_master #(
  parameter int AW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  // command port
  input  logic             CMD_START,
  input  logic             CMD_WRITE,
  input  logic [AW-1:0]    CMD_ADDR,
  input  logic [31:0]      CMD_WDATA,
  output logic             CMD_IDLE,
  output logic             RSP_VALID,
  output logic [1:0]       RSP_RESP,
  output logic [31:0]      RSP_RDATA,
  output logic [CNT_W-1:0] RSP_CYCLES,
  // write address channel
  output logic [AW-1:0]    M_AXI_AWADDR,
  output logic             M_AXI_AWVALID,
  output logic [2:0]       M_AXI_AWPROT,
  input  logic             M_AXI_AWREADY,
  // write data channel
  output logic [31:0]      M_AXI_WDATA,
  output logic [3:0]       M_AXI_WSTRB,
  output logic             M_AXI_WVALID,
  input  logic             M_AXI_WREADY,
  // write response channel
  input  logic [1:0]       M_AXI_BRESP,
  input  logic             M_AXI_BVALID,
  output logic             M_AXI_BREADY,
  // read address channel
  output logic [AW-1:0]    M_AXI_ARADDR,
  output logic             M_AXI_ARVALID,
  output logic [2:0]       M_AXI_ARPROT,
  input  logic             M_AXI_ARREADY,
  // read data channel
  input  logic [31:0]      M_AXI_RDATA,
  input  logic [1:0]       M_AXI_RRESP,
  input  logic             M_AXI_RVALID,
  output logic             M_AXI_RREADY
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_WRESP = 3'd2;
  localparam logic [2:0] S_RADDR = 3'd3;
  localparam logic [2:0] S_RDATA = 3'd4;

  logic [2:0]       state;
  logic [AW-1:0]    addr_q;
  logic [31:0]      wdata_q;
  logic             awvalid;
  logic             wvalid;
  logic             bready;
  logic             arvalid;
  logic             rready;
  logic             rsp_valid;
  logic [1:0]       rsp_resp;
  logic [31:0]      rsp_rdata;
  logic [CNT_W-1:0] cycles;

  // A write channel counts as finished once its VALID has already dropped or
  // its handshake completes on this edge; AW and W finish independently.
  logic aw_ok;
  logic w_ok;
  assign aw_ok = ~awvalid | M_AXI_AWREADY;
  assign w_ok  = ~wvalid  | M_AXI_WREADY;

  // Transaction sequencer, channel handshakes, response capture and latency count
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_resp  <= 2'b00;
      rsp_rdata <= '0;
      cycles    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      // latency counter advances on every busy cycle and saturates
      if (state != S_IDLE && cycles != {CNT_W{1'b1}}) begin
        cycles <= cycles + 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (CMD_START) begin
            addr_q  <= CMD_ADDR;
            wdata_q <= CMD_WDATA;
            cycles  <= '0;
            if (CMD_WRITE) begin
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= S_WRITE;
            end else begin
              arvalid <= 1'b1;
              state   <= S_RADDR;
            end
          end
        end
        S_WRITE: begin
          if (awvalid && M_AXI_AWREADY) awvalid <= 1'b0;
          if (wvalid && M_AXI_WREADY)   wvalid  <= 1'b0;
          if (aw_ok && w_ok) begin
            bready <= 1'b1;
            state  <= S_WRESP;
          end
        end
        S_WRESP: begin
          if (M_AXI_BVALID) begin
            bready    <= 1'b0;
            rsp_resp  <= M_AXI_BRESP;
            rsp_valid <= 1'b1;
            state     <= S_IDLE;
          end
        end
        S_RADDR: begin
          if (M_AXI_ARREADY) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (M_AXI_RVALID) begin
            rready    <= 1'b0;
            rsp_rdata <= M_AXI_RDATA;
            rsp_resp  <= M_AXI_RRESP;
            rsp_valid <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          awvalid <= 1'b0;
          wvalid  <= 1'b0;
          bready  <= 1'b0;
          arvalid <= 1'b0;
          rready  <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  assign CMD_IDLE      = (state == S_IDLE);
  assign RSP_VALID     = rsp_valid;
  assign RSP_RESP      = rsp_resp;
  assign RSP_RDATA     = rsp_rdata;
  assign RSP_CYCLES    = cycles;

  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWVALID = awvalid;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_WVALID  = wvalid;
  assign M_AXI_BREADY  = bready;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARVALID = arvalid;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_RREADY  = rready;

endmodule

`default_nettype wire

// File: tb/tb_axil_cmd_master.sv
// ============================================================================
// Module   : tb_axil_cmd_master
// Purpose  : Self-checking bench for axil_cmd_master with a delay-programmable
//            AXI4-Lite register slave and a register-file reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axil_cmd_master;

  logic        clk = 1'b0;
  logic        resetn;
  logic        CMD_START, CMD_WRITE;
  logic [31:0] CMD_ADDR, CMD_WDATA;
  logic        CMD_IDLE, RSP_VALID;
  logic [1:0]  RSP_RESP;
  logic [31:0] RSP_RDATA;
  logic [15:0] RSP_CYCLES;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]  M_AXI_WSTRB;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;

  axil_cmd_master #(.AW(32), .CNT_W(16)) dut (
    .clk(clk), .resetn(resetn),
    .CMD_START(CMD_START), .CMD_WRITE(CMD_WRITE), .CMD_ADDR(CMD_ADDR),
    .CMD_WDATA(CMD_WDATA), .CMD_IDLE(CMD_IDLE), .RSP_VALID(RSP_VALID),
    .RSP_RESP(RSP_RESP), .RSP_RDATA(RSP_RDATA), .RSP_CYCLES(RSP_CYCLES),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // slave configuration: cycles of VALID before READY, response code
  int         cfg_aw, cfg_w, cfg_b, cfg_ar, cfg_r;
  logic [1:0] cfg_resp;

  // reference model
  logic [31:0] model [32];
  logic [31:0] exp_rdata;

  // slave state
  logic [31:0] mem [32];
  logic        aw_got, w_got, b_hs, ar_got, r_hs;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  int          aw_total = 0, ar_total = 0;
  logic        p_rst, p_awv, p_awhs, p_wv, p_whs, p_arv, p_arhs;
  logic [31:0] p_awaddr, p_wdata, p_araddr;

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i]   = '0;
      model[i] = '0;
    end
  end

  // AXI4-Lite slave plus channel-stability monitor, evaluated on falling edges
  always @(negedge clk) begin
    if (!resetn) begin
      M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
      M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RRESP = 0; M_AXI_RDATA = 0;
      aw_got = 0; w_got = 0; b_hs = 0; ar_got = 0; r_hs = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      p_rst = 0; p_awv = 0; p_awhs = 0; p_wv = 0; p_whs = 0; p_arv = 0; p_arhs = 0;
    end else begin
      if (p_rst) begin
        if (p_awv && !p_awhs) begin
          chk("awvalid_hold", M_AXI_AWVALID, 1'b1);
          chk("awaddr_hold", M_AXI_AWADDR, p_awaddr);
        end
        if (p_wv && !p_whs) begin
          chk("wvalid_hold", M_AXI_WVALID, 1'b1);
          chk("wdata_hold", M_AXI_WDATA, p_wdata);
        end
        if (p_arv && !p_arhs) begin
          chk("arvalid_hold", M_AXI_ARVALID, 1'b1);
          chk("araddr_hold", M_AXI_ARADDR, p_araddr);
        end
      end
      if (b_hs) begin
        M_AXI_BVALID = 0; aw_got = 0; w_got = 0; b_hs = 0; b_cnt = 0;
      end
      if (r_hs) begin
        M_AXI_RVALID = 0; ar_got = 0; r_hs = 0; r_cnt = 0;
      end
      if (aw_got && w_got && !M_AXI_BVALID) begin
        if (b_cnt >= cfg_b) begin
          M_AXI_BVALID = 1; M_AXI_BRESP = cfg_resp;
        end else b_cnt++;
      end
      if (M_AXI_BVALID && M_AXI_BREADY) begin
        b_hs = 1;
        if (M_AXI_BRESP == 2'b00) mem[cap_awaddr[6:2]] = cap_wdata;
      end
      if (ar_got && !M_AXI_RVALID) begin
        if (r_cnt >= cfg_r) begin
          M_AXI_RVALID = 1; M_AXI_RRESP = cfg_resp;
          M_AXI_RDATA  = (cfg_resp == 2'b00) ? mem[cap_araddr[6:2]] : exp_rdata;
        end else r_cnt++;
      end
      if (M_AXI_RVALID && M_AXI_RREADY) r_hs = 1;
      M_AXI_AWREADY = 0;
      if (M_AXI_AWVALID && !aw_got) begin
        M_AXI_AWREADY = (aw_cnt >= cfg_aw); aw_cnt++;
      end
      if (M_AXI_AWVALID && M_AXI_AWREADY) begin
        aw_got = 1; aw_cnt = 0; cap_awaddr = M_AXI_AWADDR; aw_total++;
        chk("awprot", M_AXI_AWPROT, 3'b000);
      end
      M_AXI_WREADY = 0;
      if (M_AXI_WVALID && !w_got) begin
        M_AXI_WREADY = (w_cnt >= cfg_w); w_cnt++;
      end
      if (M_AXI_WVALID && M_AXI_WREADY) begin
        w_got = 1; w_cnt = 0; cap_wdata = M_AXI_WDATA;
        chk("wstrb", M_AXI_WSTRB, 4'hF);
      end
      M_AXI_ARREADY = 0;
      if (M_AXI_ARVALID && !ar_got) begin
        M_AXI_ARREADY = (ar_cnt >= cfg_ar); ar_cnt++;
      end
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        ar_got = 1; ar_cnt = 0; cap_araddr = M_AXI_ARADDR; ar_total++;
        chk("arprot", M_AXI_ARPROT, 3'b000);
      end
      p_rst = 1;
      p_awv = M_AXI_AWVALID; p_awhs = M_AXI_AWVALID && M_AXI_AWREADY; p_awaddr = M_AXI_AWADDR;
      p_wv  = M_AXI_WVALID;  p_whs  = M_AXI_WVALID && M_AXI_WREADY;   p_wdata  = M_AXI_WDATA;
      p_arv = M_AXI_ARVALID; p_arhs = M_AXI_ARVALID && M_AXI_ARREADY; p_araddr = M_AXI_ARADDR;
    end
  end

  // Issue one command (called at posedge+1) and check the completed transaction.
  // b2b leaves the bench in the response cycle so the next call starts at once;
  // poke pulses a conflicting CMD_START while the block is busy.
  task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input int daw, input int dw, input int db, input int dar,
                         input int dr, input logic [1:0] resp, input bit b2b,
                         input bit poke, output int cyc);
    int n;
    int aw0, ar0;
    cfg_aw = daw; cfg_w = dw; cfg_b = db; cfg_ar = dar; cfg_r = dr; cfg_resp = resp;
    aw0 = aw_total; ar0 = ar_total;
    CMD_WRITE = wr; CMD_ADDR = addr; CMD_WDATA = data; CMD_START = 1;
    @(posedge clk); #1;
    CMD_START = 0;
    chk("busy_after_start", CMD_IDLE, 1'b0);
    n = 0;
    while (!RSP_VALID && n < 300) begin
      if (poke && n == 1) begin
        CMD_START = 1; CMD_WRITE = ~wr; CMD_ADDR = addr ^ 32'h40; CMD_WDATA = ~data;
      end else CMD_START = 0;
      @(posedge clk); #1;
      n++;
    end
    CMD_START = 0;
    cyc = n;
    chk("rsp_valid_seen", RSP_VALID, 1'b1);
    chk("idle_in_rsp", CMD_IDLE, 1'b1);
    chk("rsp_resp", RSP_RESP, resp);
    chk("rsp_cycles", RSP_CYCLES, n);
    if (wr) begin
      chk("aw_count", aw_total - aw0, 1);
      chk("ar_count", ar_total - ar0, 0);
      chk("awaddr", cap_awaddr, addr);
      chk("wdata", cap_wdata, data);
      if (resp == 2'b00) model[addr[6:2]] = data;
    end else begin
      chk("ar_count", ar_total - ar0, 1);
      chk("aw_count", aw_total - aw0, 0);
      chk("araddr", cap_araddr, addr);
      if (resp == 2'b00) exp_rdata = model[addr[6:2]];
    end
    chk("rsp_rdata", RSP_RDATA, exp_rdata);
    if (!b2b) begin
      @(posedge clk); #1;
      chk("rsp_pulse", RSP_VALID, 1'b0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         c;
    logic [1:0] rr;
    logic [31:0] a;
    resetn = 0; CMD_START = 0; CMD_WRITE = 0; CMD_ADDR = 0; CMD_WDATA = 0;
    cfg_aw = 0; cfg_w = 0; cfg_b = 0; cfg_ar = 0; cfg_r = 0; cfg_resp = 0;
    exp_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_idle", CMD_IDLE, 1'b1);
    chk("rst_rsp_valid", RSP_VALID, 1'b0);
    chk("rst_resp", RSP_RESP, 2'b00);
    chk("rst_rdata", RSP_RDATA, 32'h0);
    chk("rst_cycles", RSP_CYCLES, 16'h0);
    chk("rst_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY}, 5'b0);
    resetn = 1;
    @(posedge clk); #1;

    // minimum-latency write then read-back of register 3
    run_cmd(1, 32'h0C, 32'h1234, 0, 0, 0, 0, 0, 2'b00, 0, 0, c);
    chk("t1_cycles", c, 2);
    chk("t1_slave_reg3", mem[3], 32'h1234);
    run_cmd(0, 32'h0C, 32'h0, 0, 0, 0, 0, 0, 2'b00, 0, 0, c);
    chk("t2_cycles", c, 2);
    chk("t2_rdata", RSP_RDATA, 32'h1234);

    // W accepted three cycles before AW
    run_cmd(1, 32'h10, 32'hCAFE_F00D, 3, 0, 0, 0, 0, 2'b00, 0, 0, c);
    chk("t3_cycles", c, 5);

    // decode error on read keeps earlier read data
    run_cmd(0, 32'h7C, 32'h0, 0, 0, 0, 1, 2, 2'b11, 0, 0, c);
    chk("t4_rdata_held", RSP_RDATA, 32'h1234);

    // busy command ignored, then back-to-back accept in the response cycle
    run_cmd(1, 32'h14, 32'h5555_AAAA, 3, 2, 1, 0, 0, 2'b00, 0, 1, c);
    run_cmd(1, 32'h18, 32'h0BAD_BEEF, 0, 1, 0, 0, 0, 2'b00, 1, 0, c);
    run_cmd(0, 32'h18, 32'h0, 0, 0, 0, 0, 1, 2'b00, 0, 0, c);
    chk("t5_b2b_rdata", RSP_RDATA, 32'h0BAD_BEEF);

    // randomized traffic against the register-file model
    for (int i = 0; i < 30; i++) begin
      rr = 2'($urandom_range(0, 3));
      if (rr == 2'b01) rr = 2'b00;
      a = {25'h0, 5'($urandom_range(0, 31)), 2'b00};
      run_cmd(1'($urandom_range(0, 1)), a, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), rr,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), c);
    end
    @(posedge clk); #1;

    // reset while waiting for a response that never comes
    cfg_aw = 0; cfg_w = 0; cfg_b = 1000; cfg_ar = 0; cfg_r = 0; cfg_resp = 0;
    CMD_WRITE = 1; CMD_ADDR = 32'h20; CMD_WDATA = 32'h7777_7777; CMD_START = 1;
    @(posedge clk); #1;
    CMD_START = 0;
    repeat (3) begin @(posedge clk); #1; end
    chk("t6_bready_wait", M_AXI_BREADY, 1'b1);
    resetn = 0;
    @(posedge clk); #1;
    chk("t6_valids_cleared", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY}, 5'b0);
    chk("t6_idle", CMD_IDLE, 1'b1);
    chk("t6_no_rsp", RSP_VALID, 1'b0);
    chk("t6_cycles", RSP_CYCLES, 16'h0);
    chk("t6_rdata", RSP_RDATA, 32'h0);
    exp_rdata = 0;
    resetn = 1;
    @(posedge clk); #1;
    chk("t6_no_rsp_after", RSP_VALID, 1'b0);
    run_cmd(0, 32'h0C, 32'h0, 0, 0, 0, 0, 0, 2'b00, 0, 0, c);
    chk("t6_reg3_after_reset", RSP_RDATA, model[3]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
